ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 32-bit in-order RISC pipeline; sits between ID and MA, owns the EX/MA register.
//  Single-cycle ALU ops, plus an iterative shift-add multiplier and restoring divider (one shared FSM).
//  Computes the load/store effective address and forwards store data (op2) to the MA stage.
//  Valid/ready handshake on both sides; stalls ID while a multi-cycle op runs or EX/MA is held.
// PARAMETERS
//  XLEN     32  datapath width
//  ITER     32  iterations per MUL/DIV/REM (must equal XLEN)
//  PC_W     32  program counter width
// PORTS
//  clk           in   1     clock, all state on rising edge
//  rst_n         in   1     asynchronous, active-low reset
//  flush         in   1     synchronous kill of EX contents (branch redirect)
//  id_ex_valid   in   1     upstream bundle valid
//  id_ex_ready   out  1     EX can accept this cycle
//  id_pc         in   PC_W  instruction PC
//  id_instr      in   32    raw instruction (passed through)
//  id_op1        in   XLEN  rs1 value
//  id_op2        in   XLEN  rs2 value (also store data)
//  id_imm        in   XLEN  sign-extended immediate
//  id_use_imm    in   1     operand B = imm (else op2)
//  id_alu_op     in   4     operation code (see BEHAVIOUR)
//  id_is_ld      in   1     load; id_is_st in 1 store; id_wb_en in 1 writes rd
//  id_rd         in   5     destination register
//  ex_ma_valid   out  1     EX/MA register valid
//  ex_ma_ready   in   1     MA accepts EX/MA contents this cycle
//  ex_ma_pc/instr/alu_result/op2/rd/is_ld/is_st/wb_en  out  (widths as inputs)  registered bundle
// BEHAVIOUR
//  Reset: all outputs 0; id_ex_ready=1 once out of reset; FSM=IDLE; counter=0.
//  Op codes: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA (shamt=B[4:0]) 8 SLT 9 SLTU
//   10 MUL (low XLEN bits) 11 DIVU 12 REMU; 13-15 = ADD. All arithmetic mod 2^XLEN.
//  Load/store use ADD (op1+imm); result is the byte address passed to MA unchanged.
//  out_free = !ex_ma_valid | ex_ma_ready.
//  Accept = id_ex_valid & id_ex_ready. id_ex_ready = (state==IDLE) & out_free & !flush.
//  Single-cycle op accepted at edge N: EX/MA bundle loaded, ex_ma_valid=1 after edge N (latency 1).
//  Pure bubble: out_free & no accept -> ex_ma_valid cleared at edge; held bundle stable while !ex_ma_ready.
//  FSM IDLE->BUSY on accept of op 10-12 (operands, op, rd, pc, instr captured; cnt=0).
//  BUSY: one iteration per cycle, cnt++; at cnt==ITER-1 do last iteration, go DONE.
//  DONE: when out_free, load result into EX/MA, go IDLE; else hold DONE.
//  MUL/DIV latency: accept edge E0, iterations E1..E32, ex_ma_valid=1 after E33 (if out_free).
//  DIVU by 0: quotient = all-ones; REMU by 0: remainder = dividend. No exceptions raised.
//  flush: at edge, ex_ma_valid<=0, FSM->IDLE, cnt<=0; input on same cycle not accepted.
//  flush overrides ex_ma_ready and any DONE transfer in same cycle.
//  Reset mid-operation: everything returns to reset values immediately (asynchronous).
//  No combinational path from id_* to ex_ma_*; id_ex_ready depends only on state, ex_ma_valid,
//   ex_ma_ready, flush.
// TESTING
//  ADD op1=5 imm=-3 use_imm=1, ready=1 -> next cycle ex_ma_valid=1, alu_result=2.
//  SRA op1=0x80000000 B=4 -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT -> 0.
//  MUL 0xFFFF x 0x10001 -> 0xFFFFFFFF, valid exactly 33 edges after accept; id_ex_ready=0 throughout.
//  DIVU 100/7 -> 14, REMU -> 2; DIVU 9/0 -> 0xFFFFFFFF, REMU 9/0 -> 9.
//  ex_ma_ready=0 for 3 cycles with valid bundle -> bundle stable, id_ex_ready=0, no loss/dup.
//  flush at cycle 10 of a DIV -> ex_ma_valid=0, id_ex_ready=1 next cycle; rst_n low mid-MUL -> all 0.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage with single-cycle ALU, iterative MUL/DIVU/REMU and the EX/MA register.
module ex_stage #(
  parameter int XLEN = 32,
  parameter int ITER = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_ex_valid,
  output logic            id_ex_ready,
  input  logic [PC_W-1:0] id_pc,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_op1,
  input  logic [XLEN-1:0] id_op2,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic [3:0]      id_alu_op,
  input  logic            id_is_ld,
  input  logic            id_is_st,
  input  logic            id_wb_en,
  input  logic [4:0]      id_rd,
  output logic            ex_ma_valid,
  input  logic            ex_ma_ready,
  output logic [PC_W-1:0] ex_ma_pc,
  output logic [31:0]     ex_ma_instr,
  output logic [XLEN-1:0] ex_ma_alu_result,
  output logic [XLEN-1:0] ex_ma_op2,
  output logic [4:0]      ex_ma_rd,
  output logic            ex_ma_is_ld,
  output logic            ex_ma_is_st,
  output logic            ex_ma_wb_en
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(ITER);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] b_op, alu, ma, mb, acc, ma_n, mb_n, acc_n;
  logic [XLEN:0] t, ts;
  logic [3:0] op_r;
  logic out_free, accept, mem, multi, div;
  assign b_op = id_use_imm ? id_imm : id_op2;
  assign mem = id_is_ld | id_is_st;
  assign multi = !mem && id_alu_op >= 4'd10 && id_alu_op <= 4'd12;
  assign out_free = !ex_ma_valid | ex_ma_ready;
  assign id_ex_ready = (state == IDLE) & out_free & !flush;
  assign accept = id_ex_valid & id_ex_ready;
  always_comb begin
    alu = id_op1 + b_op;
    if (mem) alu = id_op1 + id_imm;
    else
      case (id_alu_op)
        4'd1: alu = id_op1 - b_op;
        4'd2: alu = id_op1 & b_op;
        4'd3: alu = id_op1 | b_op;
        4'd4: alu = id_op1 ^ b_op;
        4'd5: alu = id_op1 << b_op[4:0];
        4'd6: alu = id_op1 >> b_op[4:0];
        4'd7: alu = $signed(id_op1) >>> b_op[4:0];
        4'd8: alu = {{(XLEN-1){1'b0}}, $signed(id_op1) < $signed(b_op)};
        4'd9: alu = {{(XLEN-1){1'b0}}, id_op1 < b_op};
        default: alu = id_op1 + b_op;
      endcase
  end
  // MUL: ma multiplicand, mb multiplier, acc product; DIV: ma divisor, mb dividend->quotient, acc remainder
  always_comb begin
    div = op_r != 4'd10;
    t = {acc, mb[XLEN-1]};
    ts = t - {1'b0, ma};
    acc_n = div ? (ts[XLEN] ? t[XLEN-1:0] : ts[XLEN-1:0]) : acc + (mb[0] ? ma : '0);
    mb_n = div ? {mb[XLEN-2:0], !ts[XLEN]} : mb >> 1;
    ma_n = div ? ma : ma << 1;
  end
  always_comb begin
    state_n = flush ? IDLE :
              state == IDLE ? (accept && multi ? BUSY : IDLE) :
              state == BUSY ? (cnt == CW'(ITER-1) ? DONE : BUSY) :
              (out_free ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ma <= '0;
      mb <= '0;
      acc <= '0;
      op_r <= '0;
    end else begin
      state <= state_n;
      cnt <= (flush || state != BUSY) ? '0 : cnt + 1'b1;
      if (accept && multi) begin
        op_r <= id_alu_op;
        acc <= '0;
        ma <= id_alu_op == 4'd10 ? id_op1 : b_op;
        mb <= id_alu_op == 4'd10 ? b_op : id_op1;
      end else if (state == BUSY) begin
        ma <= ma_n;
        mb <= mb_n;
        acc <= acc_n;
      end
    end
  end
  // metadata of a multi-cycle op is parked in EX/MA with valid low until the result lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ma_valid <= 1'b0;
      ex_ma_pc <= '0;
      ex_ma_instr <= '0;
      ex_ma_alu_result <= '0;
      ex_ma_op2 <= '0;
      ex_ma_rd <= '0;
      ex_ma_is_ld <= 1'b0;
      ex_ma_is_st <= 1'b0;
      ex_ma_wb_en <= 1'b0;
    end else if (flush) begin
      ex_ma_valid <= 1'b0;
    end else if (accept) begin
      ex_ma_valid <= !multi;
      ex_ma_pc <= id_pc;
      ex_ma_instr <= id_instr;
      ex_ma_alu_result <= alu;
      ex_ma_op2 <= id_op2;
      ex_ma_rd <= id_rd;
      ex_ma_is_ld <= id_is_ld;
      ex_ma_is_st <= id_is_st;
      ex_ma_wb_en <= id_wb_en;
    end else if (state == DONE && out_free) begin
      ex_ma_valid <= 1'b1;
      ex_ma_alu_result <= op_r == 4'd11 ? mb : acc;
    end else if (out_free) begin
      ex_ma_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage with a behavioural ALU/MUL/DIV reference.
module tb_ex_stage;
  logic clk = 0, rst_n = 0, flush = 0, id_ex_valid = 0, id_ex_ready;
  logic [31:0] id_pc = 0, id_instr = 0, id_op1 = 0, id_op2 = 0, id_imm = 0;
  logic id_use_imm = 0, id_is_ld = 0, id_is_st = 0, id_wb_en = 0;
  logic [3:0] id_alu_op = 0;
  logic [4:0] id_rd = 0;
  logic ex_ma_valid, ex_ma_ready = 1, ex_ma_is_ld, ex_ma_is_st, ex_ma_wb_en;
  logic [31:0] ex_ma_pc, ex_ma_instr, ex_ma_alu_result, ex_ma_op2;
  logic [4:0] ex_ma_rd;
  typedef struct packed {
    logic [31:0] pc, instr, res, op2;
    logic [4:0] rd;
    logic ld, st, wb;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  logic rmode = 0;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_ex_valid(id_ex_valid), .id_ex_ready(id_ex_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_op1(id_op1), .id_op2(id_op2), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_op(id_alu_op), .id_is_ld(id_is_ld), .id_is_st(id_is_st),
    .id_wb_en(id_wb_en), .id_rd(id_rd), .ex_ma_valid(ex_ma_valid), .ex_ma_ready(ex_ma_ready),
    .ex_ma_pc(ex_ma_pc), .ex_ma_instr(ex_ma_instr), .ex_ma_alu_result(ex_ma_alu_result),
    .ex_ma_op2(ex_ma_op2), .ex_ma_rd(ex_ma_rd), .ex_ma_is_ld(ex_ma_is_ld),
    .ex_ma_is_st(ex_ma_is_st), .ex_ma_wb_en(ex_ma_wb_en)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
    case (op)
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $signed(a) >>> b[4:0];
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      4'd10: return a * b;
      4'd11: return b == 0 ? 32'hFFFF_FFFF : a / b;
      4'd12: return b == 0 ? a : a % b;
      default: return a + b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // called at a falling edge; returns at the falling edge after the accepting edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, b2, imm, input logic ui, ld, st);
    exp_t e;
    int n;
    id_pc = $urandom; id_instr = $urandom; id_rd = 5'($urandom); id_wb_en = 1'($urandom);
    id_op1 = a; id_op2 = b2; id_imm = imm; id_use_imm = ui; id_alu_op = op;
    id_is_ld = ld; id_is_st = st; id_ex_valid = 1;
    e.pc = id_pc; e.instr = id_instr; e.op2 = b2; e.rd = id_rd;
    e.ld = ld; e.st = st; e.wb = id_wb_en;
    e.res = (ld | st) ? a + imm : ref_alu(op, a, ui ? imm : b2);
    n = 0;
    #1;
    while (!id_ex_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!id_ex_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout actual=0 expected=1");
    end else q.push_back(e);
    @(negedge clk);
    id_ex_valid = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    #1 q.delete();
    @(negedge clk);
    flush = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if (rmode) ex_ma_ready = 1'($urandom_range(0, 1));
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && !flush && ex_ma_valid && ex_ma_ready) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_output actual=%h expected=none", ex_ma_alu_result);
      end else begin
        e = q.pop_front();
        chk("result", ex_ma_alu_result, e.res);
        chk("bundle", {ex_ma_pc, ex_ma_instr, ex_ma_op2, ex_ma_rd, ex_ma_is_ld, ex_ma_is_st, ex_ma_wb_en},
            {e.pc, e.instr, e.op2, e.rd, e.ld, e.st, e.wb});
      end
    end
  end

  initial begin
    int lat, viol, n;
    logic [3:0] op;
    logic mem, ld;
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    chk("reset_valid", ex_ma_valid, 0);
    chk("reset_result", {ex_ma_alu_result, ex_ma_pc, ex_ma_rd}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("reset_ready", id_ex_ready, 1);
    issue(4'd0, 32'd5, 32'd0, 32'hFFFF_FFFD, 1, 0, 0);
    chk("add_latency", ex_ma_valid, 1);
    chk("add_value", ex_ma_alu_result, 32'd2);
    issue(4'd7, 32'h8000_0000, 32'd0, 32'd4, 1, 0, 0);
    issue(4'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 0, 0);
    issue(4'd8, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 0, 0);
    issue(4'd0, 32'h1000, 32'd0, 32'h24, 0, 1, 0);
    issue(4'd10, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 0, 0, 0);
    lat = 0; viol = 0;
    while (!ex_ma_valid && lat < 100) begin
      if (id_ex_ready) viol++;
      @(negedge clk);
      lat++;
    end
    chk("mul_latency", lat, 33);
    chk("mul_ready_low", viol, 0);
    issue(4'd11, 32'd100, 32'd7, 32'd0, 0, 0, 0);
    issue(4'd12, 32'd100, 32'd7, 32'd0, 0, 0, 0);
    issue(4'd11, 32'd9, 32'd0, 32'd0, 0, 0, 0);
    issue(4'd12, 32'd9, 32'd0, 32'd0, 0, 0, 0);
    n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    ex_ma_ready = 0;
    issue(4'd0, 32'd10, 32'd20, 32'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", ex_ma_valid, 1);
      chk("stall_result", ex_ma_alu_result, 32'd30);
      chk("stall_ready", id_ex_ready, 0);
      @(negedge clk);
    end
    ex_ma_ready = 1;
    @(negedge clk);
    chk("stall_no_dup", ex_ma_valid, 0);
    issue(4'd11, 32'd1000, 32'd3, 32'd0, 0, 0, 0);
    repeat (9) @(negedge clk);
    do_flush();
    chk("flush_valid", ex_ma_valid, 0);
    #1 chk("flush_ready", id_ex_ready, 1);
    repeat (40) @(negedge clk);
    issue(4'd10, 32'h1234, 32'h5678, 32'd0, 0, 0, 0);
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    q.delete();
    chk("rst_mid_valid", ex_ma_valid, 0);
    chk("rst_mid_bundle", {ex_ma_alu_result, ex_ma_pc, ex_ma_instr, ex_ma_op2, ex_ma_rd, ex_ma_wb_en}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (40) @(negedge clk);
    chk("rst_mid_ready", id_ex_ready, 1);
    rmode = 1;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      mem = $urandom_range(0, 7) == 0;
      ld = mem & 1'($urandom);
      a = $urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : $urandom;
      b = $urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : $urandom;
      issue(op, a, b, $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40), 1'($urandom), ld, mem & !ld);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(0, 40)) @(negedge clk);
        do_flush();
      end
    end
    n = 0;
    while (q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
